// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, error codes and state type for the UART input parser
package uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int ERR_NONE     = 0;
    localparam int ERR_INVALID  = 1;
    localparam int ERR_OVERFLOW = 2;
    localparam int ERR_EMPTY    = 3;

    localparam int HEX_SIZE   = 4;
    localparam int ASCII_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGITS  = 2'd1,
        DISCARD = 2'd2
    } state_t;

endpackage

// File: rtl/uart_input_parser_ascii_to_hex.sv
// rtl/uart_input_parser_ascii_to_hex.sv - combinational ASCII hex character to nibble converter
//
// Ports:
//   ascii   in  8  ASCII character
//   is_hex  out 1  character is 0-9, A-F or a-f
//   nibble  out 4  value of the character (0 when not hex)
module ascii_to_hex
    import uart_pkg::*;
(
    input  logic [ASCII_SIZE-1:0] ascii,
    output logic                  is_hex,
    output logic [HEX_SIZE-1:0]   nibble
);

    always_comb begin
        is_hex = 1'b0;
        nibble = '0;
        if (ascii >= 8'h30 && ascii <= 8'h39) begin
            is_hex = 1'b1;
            nibble = HEX_SIZE'(ascii - 8'h30);
        end else if (ascii >= 8'h41 && ascii <= 8'h46) begin
            is_hex = 1'b1;
            nibble = HEX_SIZE'(ascii - 8'h37);
        end else if (ascii >= 8'h61 && ascii <= 8'h66) begin
            is_hex = 1'b1;
            nibble = HEX_SIZE'(ascii - 8'h57);
        end
    end

endmodule

// File: rtl/uart_input_parser.sv
// rtl/uart_input_parser.sv - assembles a CR/LF terminated ASCII hex line into a value
//
// Ports:
//   clk        in  1                    system clock, rising edge
//   reset      in  1                    asynchronous reset, active-low
//   rx_valid   in  1                    strobe: rx_data holds a received byte
//   rx_data    in  8                    received ASCII byte
//   ready_out  out 1                    one-cycle strobe: line complete
//   data_out   out 4*RESULT_SIZE        parsed value, first digit in MSB nibble
//   error_out  out $clog2(ERROR_COUNT)  0 none, 1 invalid, 2 overflow, 3 empty line
//
// Optional: define UART_INPUT_TIMEOUT_EN to abandon a partial line silently
// after CLOCK_RATE/1_000_000*TIMEOUT_US cycles without a received byte.
module uart_input_parser
    import uart_pkg::*;
#(
    parameter int RESULT_SIZE = 1,
    parameter int ERROR_COUNT = 4,
    parameter int CLOCK_RATE  = 100_000_000,
    parameter int TIMEOUT_US  = 1000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rx_valid,
    input  logic [ASCII_SIZE-1:0]          rx_data,
    output logic                           ready_out,
    output logic [HEX_SIZE*RESULT_SIZE-1:0] data_out,
    output logic [$clog2(ERROR_COUNT)-1:0] error_out
);

    localparam int DW = HEX_SIZE * RESULT_SIZE;
    localparam int EW = $clog2(ERROR_COUNT);
    localparam int CW = $clog2(RESULT_SIZE + 1);

    state_t              state;
    logic [DW-1:0]       acc;
    logic [CW-1:0]       count;
    logic [EW-1:0]       err;
    logic                cr_seen;

    logic                is_hex;
    logic [HEX_SIZE-1:0] nibble;
    logic                is_term;

    ascii_to_hex u_ascii_to_hex (
        .ascii  (rx_data),
        .is_hex (is_hex),
        .nibble (nibble)
    );

    assign is_term = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);

`ifdef UART_INPUT_TIMEOUT_EN
    localparam int TMO_LIMIT = CLOCK_RATE / 1_000_000 * TIMEOUT_US;
    localparam int TW        = $clog2(TMO_LIMIT + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            err       <= '0;
            cr_seen   <= 1'b0;
            ready_out <= 1'b0;
            data_out  <= '0;
            error_out <= '0;
`ifdef UART_INPUT_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            ready_out <= 1'b0;
            if (rx_valid) begin
                cr_seen <= is_term && (rx_data == ASCII_CR);
`ifdef UART_INPUT_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
                unique case (state)
                    IDLE: begin
                        if (is_hex) begin
                            // acc is always zero in IDLE, so the first digit lands alone
                            acc   <= DW'(nibble);
                            count <= CW'(1);
                            state <= DIGITS;
                        end else if (is_term) begin
                            // LF straight after CR is the second half of a CRLF pair
                            if (!((rx_data == ASCII_LF) && cr_seen)) begin
                                ready_out <= 1'b1;
                                data_out  <= '0;
                                error_out <= EW'(ERR_EMPTY);
                            end
                        end else begin
                            err   <= EW'(ERR_INVALID);
                            state <= DISCARD;
                        end
                    end
                    DIGITS: begin
                        if (is_hex) begin
                            if (count < CW'(RESULT_SIZE)) begin
                                acc   <= DW'({acc, nibble});
                                count <= count + CW'(1);
                            end else begin
                                err   <= EW'(ERR_OVERFLOW);
                                state <= DISCARD;
                            end
                        end else if (is_term) begin
                            ready_out <= 1'b1;
                            data_out  <= acc;
                            error_out <= EW'(ERR_NONE);
                            acc       <= '0;
                            count     <= '0;
                            state     <= IDLE;
                        end else begin
                            err   <= EW'(ERR_INVALID);
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        // err was latched on entry and is never overwritten here
                        if (is_term) begin
                            ready_out <= 1'b1;
                            data_out  <= '0;
                            error_out <= err;
                            acc       <= '0;
                            count     <= '0;
                            err       <= '0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
`ifdef UART_INPUT_TIMEOUT_EN
            else if (state != IDLE) begin
                if (tmo_cnt == TW'(TMO_LIMIT - 1)) begin
                    state   <= IDLE;
                    acc     <= '0;
                    count   <= '0;
                    err     <= '0;
                    cr_seen <= 1'b0;
                    tmo_cnt <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_input_parser.sv
// tb/tb_uart_input_parser.sv - self-checking bench for uart_input_parser
module tb_uart_input_parser;

    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        r4, r2;
    logic [15:0] d4;
    logic [7:0]  d2;
    logic [1:0]  e4, e2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_input_parser #(.RESULT_SIZE(4), .ERROR_COUNT(4), .CLOCK_RATE(1_000_000), .TIMEOUT_US(10)) u4 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .ready_out(r4), .data_out(d4), .error_out(e4));

    uart_input_parser #(.RESULT_SIZE(2), .ERROR_COUNT(4), .CLOCK_RATE(1_000_000), .TIMEOUT_US(10)) u2 (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .ready_out(r2), .data_out(d2), .error_out(e2));

    // ---------------- reference model: line buffer evaluated at the terminator
    byte unsigned line[$];
    bit           prev_cr;
    int           gap;
    logic         exp_r;
    logic [15:0]  exp_d4;
    logic [1:0]   exp_e4;
    logic [7:0]   exp_d2;
    logic [1:0]   exp_e2;

    function automatic bit hexchar(input byte unsigned c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
    endfunction

    function automatic int hexval(input byte unsigned c);
        if (c >= "0" && c <= "9") return c - "0";
        if (c >= "A" && c <= "F") return c - "A" + 10;
        return c - "a" + 10;
    endfunction

    function automatic void eval_line(input int rs, output int val, output int code);
        val  = 0;
        code = 0;
        for (int i = 0; i < line.size(); i++) begin
            if (!hexchar(line[i])) begin val = 0; code = 1; return; end
            if (i >= rs)           begin val = 0; code = 2; return; end
            val = val * 16 + hexval(line[i]);
        end
    endfunction

    task automatic model_reset();
        line.delete();
        prev_cr = 0;
        gap     = 0;
        exp_r   = 0;
        exp_d4  = 0; exp_e4 = 0;
        exp_d2  = 0; exp_e2 = 0;
    endtask

    task automatic model_byte(input byte unsigned b);
        int v, c;
        bit term;
        term = (b == 8'h0D) || (b == 8'h0A);
        if (term) begin
            if (line.size() == 0) begin
                if (!(b == 8'h0A && prev_cr)) begin
                    exp_r = 1; exp_d4 = 0; exp_e4 = 3; exp_d2 = 0; exp_e2 = 3;
                end
            end else begin
                exp_r = 1;
                eval_line(4, v, c); exp_d4 = 16'(v); exp_e4 = 2'(c);
                eval_line(2, v, c); exp_d2 = 8'(v);  exp_e2 = 2'(c);
                line.delete();
            end
        end else begin
            line.push_back(b);
        end
        prev_cr = (b == 8'h0D);
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            model_reset();
        end else begin
            exp_r = 0;
            if (rx_valid) begin
                gap = 0;
                model_byte(rx_data);
            end else begin
`ifdef UART_INPUT_TIMEOUT_EN
                if (line.size() > 0) begin
                    gap++;
                    if (gap == TMO) begin
                        line.delete();
                        prev_cr = 0;
                        gap     = 0;
                    end
                end
`endif
            end
        end
    end

    // ---------------- checking
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ready4", 32'(r4), 32'(exp_r));
        chk("ready2", 32'(r2), 32'(exp_r));
        chk("data4",  32'(d4), 32'(exp_d4));
        chk("err4",   32'(e4), 32'(exp_e4));
        chk("data2",  32'(d2), 32'(exp_d2));
        chk("err2",   32'(e2), 32'(exp_e2));
    end

    // ---------------- stimulus helpers
    task automatic put(input byte unsigned b);
        @(posedge clk);
        #1 rx_valid = 1'b1;
        rx_data = b;
    endtask

    task automatic put_str(input string s);
        for (int i = 0; i < s.len(); i++) put(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    // lets the terminator be sampled, then checks the strobe against literals
    task automatic pin(input string name, input logic [15:0] x4, input logic [1:0] y4,
                       input logic [7:0] x2, input logic [1:0] y2);
        idle(1);
        @(negedge clk);
        chk({name, "_pulse4"}, 32'(r4), 32'd1);
        chk({name, "_pulse2"}, 32'(r2), 32'd1);
        chk({name, "_d4"}, 32'(d4), 32'(x4));
        chk({name, "_e4"}, 32'(e4), 32'(y4));
        chk({name, "_d2"}, 32'(d2), 32'(x2));
        chk({name, "_e2"}, 32'(e2), 32'(y2));
    endtask

    task automatic pin_quiet(input string name);
        idle(1);
        @(negedge clk);
        chk({name, "_nopulse4"}, 32'(r4), 32'd0);
        chk({name, "_nopulse2"}, 32'(r2), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        rx_valid = 1'b0;
        model_reset();
        idle(2);
        reset = 1'b1;
    endtask

    function automatic byte unsigned rand_byte();
        string hx = "0123456789abcdefABCDEF";
        byte unsigned bad[7] = '{8'h47, 8'h7A, 8'h40, 8'h20, 8'h7E, 8'h00, 8'hFF};
        if ($urandom_range(0, 9) < 8) return hx[$urandom_range(0, 21)];
        return bad[$urandom_range(0, 6)];
    endfunction

    initial begin
        model_reset();
        #12;
        chk("reset_ready", 32'(r4), 32'd0);
        chk("reset_data",  32'(d4), 32'd0);
        chk("reset_err",   32'(e4), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        put_str("1a3F"); put(8'h0D);
        pin("hex4", 16'h1A3F, 2'd0, 8'h00, 2'd2);
        put(8'h0A);
        pin_quiet("crlf");

        put_str("7"); put(8'h0A);
        pin("seven", 16'h0007, 2'd0, 8'h07, 2'd0);
        put(8'h0A);
        pin("empty", 16'h0000, 2'd3, 8'h00, 2'd3);

        // back-to-back: next line starts on the cycle after the terminator
        put_str("12G4"); put(8'h0D);
        put("a");
        @(negedge clk);
        chk("inv_pulse", 32'(r2), 32'd1);
        chk("inv_e2",    32'(e2), 32'd1);
        chk("inv_e4",    32'(e4), 32'd1);
        put("b"); put(8'h0D);
        pin("ab", 16'h00AB, 2'd0, 8'hAB, 2'd0);

        put_str("123"); put(8'h0D);
        pin("ovf", 16'h0123, 2'd0, 8'h00, 2'd2);
        put_str("1G23"); put(8'h0D);
        pin("first_err", 16'h0000, 2'd1, 8'h00, 2'd1);

        put_str("12");
        do_reset();
        @(negedge clk);
        chk("post_reset_ready", 32'(r4), 32'd0);
        chk("post_reset_data",  32'(d4), 32'd0);
        put_str("5"); put(8'h0D);
        pin("after_reset", 16'h0005, 2'd0, 8'h05, 2'd0);

        put_str("3"); idle(12); put_str("4"); put(8'h0D);
`ifdef UART_INPUT_TIMEOUT_EN
        pin("timeout", 16'h0004, 2'd0, 8'h04, 2'd0);
`else
        pin("no_timeout", 16'h0034, 2'd0, 8'h34, 2'd0);
`endif

        // randomized lines, checked every cycle against the model
        for (int n = 0; n < 400; n++) begin
            int len;
            int t;
            len = $urandom_range(0, 6);
            for (int i = 0; i < len; i++) begin
                put(rand_byte());
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                if ($urandom_range(0, 40) == 0) idle(TMO + $urandom_range(0, 4));
            end
            if ($urandom_range(0, 60) == 0) do_reset();
            t = $urandom_range(0, 2);
            if (t == 0)      put(8'h0D);
            else if (t == 1) put(8'h0A);
            else begin put(8'h0D); put(8'h0A); end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 2));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_input_parser.md
Name: uart_input_parser

Overview:
- Upstream neighbour of the UART output manager.
- Consumes bytes from the UART receiver and assembles an ASCII hexadecimal line terminated by CR or LF into a RESULT_SIZE-digit value.
- Emits a one-cycle ready_out strobe with data_out and error_out.
- data_out, error_out and ready_out wire directly to the output manager's data_in, error_in and ready_in.

Parameters:
- RESULT_SIZE, 1: maximum hex digits per line; data_out width is 4*RESULT_SIZE.
- ERROR_COUNT, 4: number of error codes; error_out width is $clog2(ERROR_COUNT).
- CLOCK_RATE, 100_000_000: clock frequency in Hz; used only by the optional timeout.
- TIMEOUT_US, 1000: inter-character timeout in microseconds; used only by the optional timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received ASCII byte.
- ready_out  out  1  one-cycle strobe: line complete; data_out and error_out are valid.
- data_out  out  4*RESULT_SIZE  parsed value, first digit in the MSB nibble.
- error_out  out  $clog2(ERROR_COUNT)  error code: 0 none, 1 invalid char, 2 overflow, 3 empty line.

Behaviour:
- Reset (reset=0, asynchronous): ready_out=0, data_out=0, error_out=0, digit count=0, cr_seen=0, state=IDLE.
- Bytes are processed only on cycles with rx_valid=1. rx_valid is never back-pressured.
- Character classes:
  - digit: '0'-'9', 'A'-'F', 'a'-'f', mapped to nibbles 0-F.
  - terminator: 0x0D or 0x0A.
  - anything else is invalid.
- IDLE:
  - digit: acc={acc,nibble}, count=1, go to DIGITS.
  - terminator: if the byte is LF and cr_seen=1, swallow it silently (CRLF pair). Otherwise emit error 3, data 0.
  - invalid: latch err=1, go to DISCARD.
- DIGITS:
  - digit with count<RESULT_SIZE: shift the nibble in at the LSB, count+1.
  - digit with count==RESULT_SIZE: latch err=2, go to DISCARD.
  - terminator: emit data_out=acc zero-extended (fewer digits give leading zeros), error 0, go to IDLE.
  - invalid: latch err=1, go to DISCARD.
- DISCARD:
  - Ignore all bytes until a terminator.
  - On the terminator, emit data_out=0 and error_out=latched err (the first error wins), go to IDLE.
- Emit timing:
  - ready_out=1 on the cycle after the terminator is sampled, high for exactly one cycle.
  - data_out and error_out are updated on that same edge and hold until the next emit.
- cr_seen is set when the sampled terminator is CR and cleared on any other sampled byte.
- The accumulator clears on every return to IDLE.
- A byte on the cycle immediately after a terminator is accepted normally; there is no dead cycle.
- Downstream contract: the consumer must sample ready_in in its idle state. At most one line per received terminator.
- Reset mid-line discards the partial line; no strobe is produced.

Optional Feature:
- Macro: UART_INPUT_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(CLOCK_RATE/1_000_000*TIMEOUT_US+1) runs in DIGITS and DISCARD.
  - It clears on every rx_valid.
  - On reaching CLOCK_RATE/1_000_000*TIMEOUT_US it returns to IDLE silently: no strobe, accumulator cleared, cr_seen cleared.
  - In IDLE the counter is held at 0.
- Undefined: no counter is built; partial lines wait indefinitely.

Decomposition:
- Package uart_pkg holds:
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - Error codes ERR_NONE=0, ERR_INVALID=1, ERR_OVERFLOW=2, ERR_EMPTY=3.
  - State enum IDLE/DIGITS/DISCARD.
  - HEX_SIZE=4 and ASCII_SIZE=8.
- Sub-module ascii_to_hex: combinational, 8-bit in, outputs is_hex and 4-bit nibble. It is the inverse of the existing hex-to-ASCII decoder.

Test Plan:
- RESULT_SIZE=4; bytes "1a3F",CR -> one ready_out pulse, data_out=16'h1A3F, error_out=0. A following LF produces no pulse.
- RESULT_SIZE=4; "7",LF -> data_out=16'h0007, error_out=0. Then bare LF -> pulse, data_out=0, error_out=3.
- RESULT_SIZE=2; "12G4",CR -> error_out=1, data_out=0, exactly one pulse. "ab",CR immediately after -> data_out=8'hAB, error_out=0.
- RESULT_SIZE=2; "123",CR -> error_out=2. "1G23",CR -> error_out=1 (first error kept).
- Reset asserted after "12" with no terminator; release; "5",CR -> data_out=0x05, no spurious pulse before.
- UART_INPUT_TIMEOUT_EN, CLOCK_RATE=1_000_000, TIMEOUT_US=10: "3", idle 12 cycles, "4",CR -> data_out=0x04. Without the macro -> data_out=0x34.
